fft_frame_sequencer: RTL and testbench

- Streams the stored input record from the sample memory into the FFT core as consecutive frames of FFT_POINTS samples.
- Drives the memory read port, absorbs the 1-cycle memory read latency, and presents a valid/ready stream with sop/eop markers to the FFT input.
- Replaces free-running, unconditional sample readout with start/stop control, backpressure support and a sticky completion flag.

---
 rtl/fft_frame_sequencer.sv | 111 +++++++++++
 tb/tb_fft_frame_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: streams the stored sample record into the FFT core as sop/eop-framed frames.
// Define FFT_SEQ_ZERO_PAD_EN to zero-pad the final partial frame instead of dropping the trailing samples.
module fft_frame_sequencer #(
  parameter int LENGTH = 14400,
  parameter int DATA_WIDTH = 32,
  parameter int FFT_POINTS = 1024,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_rd_data,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [15:0]                  frame_index,
  output logic                         busy,
  output logic                         done
);
`ifdef FFT_SEQ_ZERO_PAD_EN
  localparam int FRAMES = (LENGTH + FFT_POINTS - 1) / FFT_POINTS;
  localparam int READS = LENGTH;
`else
  localparam int FRAMES = LENGTH / FFT_POINTS;
  localparam int READS = FRAMES * FFT_POINTS;
`endif
  localparam int TOTAL = FRAMES * FFT_POINTS;
  localparam int PW = $clog2(FFT_POINTS);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_d;
  logic [31:0] slot, sent;
  logic [ADDR_WIDTH-1:0] addr;
  logic [PW-1:0] pos;
  logic signed [DATA_WIDTH-1:0] f [2];
  logic signed [DATA_WIDTH-1:0] in_data;
  logic [1:0] cnt;
  logic wp, rp, inflight, inflight_pad;
  logic issue, pad, xfer, last, push, pop;
  assign mem_rd_addr = addr;
  // Padding slots travel through the read pipeline like real reads so ordering and timing stay uniform.
  always_comb begin
    in_data = inflight_pad ? '0 : mem_rd_data;
    out_valid = cnt != 2'd0 || inflight;
    out_data = cnt != 2'd0 ? f[rp] : (inflight ? in_data : '0);
    out_sop = out_valid && pos == '0;
    out_eop = out_valid && pos == PW'(FFT_POINTS - 1);
    xfer = out_valid && out_ready;
    last = xfer && sent == 32'(TOTAL - 1);
    pad = slot >= 32'(READS);
    issue = state == STREAM && !abort && (cnt + {1'b0, inflight}) < 2'd2;
    mem_rd_en = issue && !pad;
    pop = xfer && cnt != 2'd0;
    push = inflight && !(xfer && cnt == 2'd0);
    busy = state != IDLE;
    state_d = state;
    if (abort) state_d = IDLE;
    else if (state == IDLE && start) state_d = TOTAL == 0 ? IDLE : STREAM;
    else if (state == STREAM && issue && slot == 32'(TOTAL - 1)) state_d = DRAIN;
    else if (state == DRAIN && last) state_d = IDLE;
  end
  always_ff @(posedge clock) if (push) f[wp] <= in_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      slot <= '0;
      sent <= '0;
      addr <= '0;
      pos <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      inflight <= 1'b0;
      inflight_pad <= 1'b0;
      frame_index <= '0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      inflight <= issue;
      inflight_pad <= pad;
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (issue) slot <= slot + 32'd1;
      if (mem_rd_en && addr != ADDR_WIDTH'(READS - 1)) addr <= addr + 1'b1;
      if (xfer) begin
        sent <= sent + 32'd1;
        pos <= pos + 1'b1;
        if (out_eop && frame_index != 16'hFFFF) frame_index <= frame_index + 16'd1;
      end
      if (last && !abort) done <= 1'b1;
      if (abort) begin
        cnt <= 2'd0;
        wp <= 1'b0;
        rp <= 1'b0;
        inflight <= 1'b0;
      end else if (state == IDLE && start) begin
        slot <= '0;
        sent <= '0;
        addr <= '0;
        pos <= '0;
        frame_index <= '0;
        done <= TOTAL == 0;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: scoreboard bench for fft_frame_sequencer with LENGTH=40, FFT_POINTS=16.
// Expectations follow FFT_SEQ_ZERO_PAD_EN when it is defined for the build.
module tb_fft_frame_sequencer;
  localparam int LENGTH = 40, FP = 16, DW = 32, AW = 6;
`ifdef FFT_SEQ_ZERO_PAD_EN
  localparam int NEXP = 48, MAXA = 39;
`else
  localparam int NEXP = 32, MAXA = 31;
`endif
  localparam int FRAMES = NEXP / FP;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic mem_rd_en, out_valid, out_sop, out_eop, busy, done;
  logic [AW-1:0] mem_rd_addr;
  logic signed [DW-1:0] mem_rd_data = '0, out_data;
  logic [15:0] frame_index;
  typedef struct packed {logic [31:0] d; logic sop; logic eop; logic [15:0] fi;} exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0, xfers = 0;
  bit mon_en = 1'b0, rnd = 1'b0, stalled = 1'b0;
  fft_frame_sequencer #(.LENGTH(LENGTH), .DATA_WIDTH(DW), .FFT_POINTS(FP), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .frame_index(frame_index),
    .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= 32'(mem_rd_addr) + 32'sd1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) if (mon_en) begin
    if (mem_rd_en) check("rd_addr_le_max", 64'(int'(mem_rd_addr) <= MAXA), 64'd1);
    if (out_valid) begin
      if (q.size() == 0) check("out_valid_unexpected", 64'(out_valid), 64'd0);
      else begin
        check("out_data", 64'(unsigned'(out_data)), 64'(q[0].d));
        check("out_sop", 64'(out_sop), 64'(q[0].sop));
        check("out_eop", 64'(out_eop), 64'(q[0].eop));
        check("frame_index", 64'(frame_index), 64'(q[0].fi));
        if (out_ready) begin
          void'(q.pop_front());
          xfers++;
        end
      end
    end
  end
  // Random backpressure that always stalls at least once on every sop and eop sample.
  initial forever begin
    @(posedge clock);
    #1;
    if (rnd && out_valid && (out_sop || out_eop) && !stalled) begin
      out_ready = 1'b0;
      stalled = 1'b1;
    end else begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
    end
  end
  task automatic load_exp();
    q.delete();
    xfers = 0;
    for (int i = 0; i < NEXP; i++)
      q.push_back('{d: (i < LENGTH) ? 32'(i + 1) : 32'd0, sop: (i % FP) == 0,
                    eop: (i % FP) == FP - 1, fi: 16'(i / FP)});
  endtask
  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask
  task automatic wait_xfers(input int n);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      if (xfers >= n) return;
    end
    check("timeout_xfers", 64'(xfers), 64'(n));
  endtask
  task automatic finish_run();
    wait_xfers(NEXP);
    @(negedge clock);
    check("done_after_last", 64'(done), 64'd1);
    check("busy_after_last", 64'(busy), 64'd0);
    check("frame_index_final", 64'(frame_index), 64'(FRAMES));
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    check("xfer_count", 64'(xfers), 64'(NEXP));
  endtask
  task automatic check_reset();
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(unsigned'(out_data)), 64'd0);
    check("rst_out_sop", 64'(out_sop), 64'd0);
    check("rst_out_eop", 64'(out_eop), 64'd0);
    check("rst_frame_index", 64'(frame_index), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog xfers=%0d", xfers);
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    load_exp();
    @(posedge clock);
    #1 start = 1'b1;
    @(negedge clock);
    check("lat_rd_en_c0", 64'(mem_rd_en), 64'd0);
    check("lat_busy_c0", 64'(busy), 64'd0);
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("lat_rd_en_c1", 64'(mem_rd_en), 64'd1);
    check("lat_rd_addr_c1", 64'(mem_rd_addr), 64'd0);
    check("lat_valid_c1", 64'(out_valid), 64'd0);
    check("lat_busy_c1", 64'(busy), 64'd1);
    @(negedge clock);
    check("lat_valid_c2", 64'(out_valid), 64'd1);
    check("lat_data_c2", 64'(unsigned'(out_data)), 64'd1);
    check("lat_sop_c2", 64'(out_sop), 64'd1);
    finish_run();
    rnd = 1'b1;
    load_exp();
    pulse_start();
    finish_run();
    rnd = 1'b0;
    load_exp();
    pulse_start();
    wait_xfers(10);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    load_exp();
    pulse_start();
    finish_run();
    load_exp();
    pulse_start();
    wait_xfers(5);
    pulse_start();
    wait_xfers(20);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    load_exp();
    pulse_start();
    finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
